fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to a one-cycle-latency
// instruction RAM, buffers returned words with their PCs in a small FIFO, and
// flushes/restarts on a pipeline redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [13:0] i_addr,
  output logic        i_req,
  input  logic [31:0] i_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  output logic        misaligned
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   tag_pc;
  logic          inflight;
  logic          running;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occupancy;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          pop;
  logic          push;
  logic          issue;

  // running stays low until the first edge after reset release, so no fetch
  // is requested while resetn is low even though the queue looks empty.
  assign occupancy = count + CW'(inflight);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = inflight && !redirect_valid;
  assign issue     = running && !redirect_valid && ((occupancy < DEPTH_C) || pop);
  assign i_req     = issue;
  assign i_addr    = fetch_pc[13:0];
  // Head outputs are masked so they read zero whenever the queue is empty.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

  // Control state: fetch PC, in-flight flag, FIFO pointers/count, redirect flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc   <= RESET_PC;
      running    <= 1'b0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misaligned <= 1'b0;
    end else begin
      running    <= 1'b1;
      misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        inflight <= issue;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Datapath storage: tag of the outstanding fetch and FIFO entry contents.
  always_ff @(posedge clk) begin
    if (issue) tag_pc <= fetch_pc;
    if (push) begin
      pc_mem[wr_ptr]    <= tag_pc;
      instr_mem[wr_ptr] <= i_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: RAM model, directed scenarios plus randomized traffic,
// with a scoreboard holding the expected in-order instruction stream.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] i_addr;
  logic        i_req;
  logic [31:0] i_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        misaligned;

  logic [31:0] mem [0:4095];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] next_pc;
  logic        prev_mis;

  int tests = 0;
  int fails = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn), .i_addr(i_addr), .i_req(i_req), .i_data(i_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Instruction RAM: word addressed by i_addr, data one cycle after request.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    forever begin
      @(posedge clk);
      i_data <= mem[i_addr[13:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: expected stream is the sequential word run from the last
  // reset/redirect target; each accepted head must match its front.
  initial begin
    exp_t e;
    next_pc  = RESET_PC;
    prev_mis = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        next_pc  = RESET_PC;
        prev_mis = 1'b0;
      end else begin
        check("misaligned_pulse", {31'd0, misaligned}, {31'd0, prev_mis});
        prev_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
          exp_q.delete();
          next_pc = {redirect_pc[31:2], 2'b00};
        end else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: got pc %h, expected nothing", out_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e.pc);
            check("sb_instr", out_instr, e.instr);
          end
        end
        while (exp_q.size() < 16) begin
          e.pc    = next_pc;
          e.instr = mem[next_pc[13:2]];
          exp_q.push_back(e);
          next_pc = next_pc + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  // Stimulus and directed checks.
  initial begin
    resetn = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_i_req", {31'd0, i_req}, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check("rst_i_addr", {18'd0, i_addr}, 32'd0);

    // Startup
    @(posedge clk); #1;
    resetn = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("start_no_early_req", {31'd0, i_req}, 32'd0);
    @(negedge clk);
    check("start_first_req", {31'd0, i_req}, 32'd1);
    check("start_first_addr", {18'd0, i_addr}, 32'd0);
    @(negedge clk);
    check("start_valid_lat", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("start_valid", {31'd0, out_valid}, 32'd1);
    check("start_pc0", out_pc, 32'h8000_0000);
    check("start_instr0", out_instr, 32'h0000_0013);
    @(negedge clk);
    check("start_pc1", out_pc, 32'h8000_0004);
    check("start_instr1", out_instr, 32'h0010_0093);

    // Backpressure
    step();
    out_ready = 1'b0;
    redirect(RESET_PC);
    repeat (10) step();
    @(negedge clk);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_req_low", {31'd0, i_req}, 32'd0);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      check("bp_drain_pc", out_pc, 32'h8000_0000 + 32'(4 * k));
    end

    // Flush with 3 queued and one in flight
    step();
    out_ready = 1'b0;
    redirect(RESET_PC);
    repeat (4) step();
    check("fl_req_low", {31'd0, i_req}, 32'd0);
    check("fl_valid_pre", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    redirect(32'h8000_0100);
    @(negedge clk);
    check("fl_valid_e0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("fl_valid_e1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("fl_valid_e2", {31'd0, out_valid}, 32'd1);
    check("fl_pc_e2", out_pc, 32'h8000_0100);
    @(negedge clk);
    check("fl_pc_e3", out_pc, 32'h8000_0104);

    // Misaligned redirect
    step();
    redirect(32'h8000_0102);
    @(negedge clk);
    check("mis_high", {31'd0, misaligned}, 32'd1);
    @(negedge clk);
    check("mis_low", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    check("mis_pc", out_pc, 32'h8000_0100);

    // Address wrap
    step();
    redirect(32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_req", {31'd0, i_req}, 32'd1);
    check("wrap_addr0", {18'd0, i_addr}, 32'h3FF8);
    @(negedge clk);
    check("wrap_addr1", {18'd0, i_addr}, 32'h3FFC);
    @(negedge clk);
    check("wrap_addr2", {18'd0, i_addr}, 32'h0000);
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc2", out_pc, 32'h0000_0000);

    // Asynchronous reset with entries queued
    step();
    out_ready = 1'b0;
    redirect(RESET_PC);
    repeat (3) step();
    check("ar_valid_pre", {31'd0, out_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_req", {31'd0, i_req}, 32'd0);
    check("ar_pc", out_pc, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("ar_no_early_req", {31'd0, i_req}, 32'd0);
    @(negedge clk);
    check("ar_restart_req", {31'd0, i_req}, 32'd1);
    check("ar_restart_addr", {18'd0, i_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("ar_restart_valid", {31'd0, out_valid}, 32'd1);
    check("ar_restart_pc", out_pc, 32'h8000_0000);

    // Randomized traffic checked by the scoreboard
    for (int n = 0; n < 400; n++) begin
      step();
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
